// File: rtl/rv_regfile_wb.sv
// 32 x XLEN RISC-V register file with a one-entry write-back staging register and read bypass.
// Optional committed-write counter (port wcnt) enabled by defining REGFILE_WCNT_EN.
module rv_regfile_wb #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we3,
   input  logic [4:0]      a3,
   input  logic [XLEN-1:0] wd3,
   input  logic [4:0]      a1,
   input  logic [4:0]      a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            wb_busy
`ifdef REGFILE_WCNT_EN
   ,
   output logic [31:0]     wcnt
`endif
);

   // x0 has no storage; index 0 is never written or read from the array.
   logic [XLEN-1:0] regs [1:NREG-1];

   logic            stg_v;
   logic [4:0]      stg_a;
   logic [XLEN-1:0] stg_d;

   // Capture into staging and commit the previous staged write on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_v <= 1'b0;
         stg_a <= '0;
         stg_d <= '0;
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         stg_v <= we3 && (a3 != 5'd0);
         stg_a <= a3;
         stg_d <= wd3;
         if (stg_v) begin
            regs[stg_a] <= stg_d;
         end
      end
   end

`ifdef REGFILE_WCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
      end else if (stg_v) begin
         wcnt <= wcnt + 32'd1;
      end
   end
`endif

   // Staged data takes priority over the array so a write is visible the cycle after it is presented.
   always_comb begin
      rd1 = '0;
      if (a1 != 5'd0) begin
         if (stg_v && (stg_a == a1)) begin
            rd1 = stg_d;
         end else begin
            rd1 = regs[a1];
         end
      end
   end

   always_comb begin
      rd2 = '0;
      if (a2 != 5'd0) begin
         if (stg_v && (stg_a == a2)) begin
            rd2 = stg_d;
         end else begin
            rd2 = regs[a2];
         end
      end
   end

   assign wb_busy = stg_v;

endmodule

// File: tb/tb_rv_regfile_wb.sv
// Bench for rv_regfile_wb: directed literal checks plus randomized traffic against
// a plain edge-written register-file model.
module tb_rv_regfile_wb;

   logic        clk;
   logic        rst_n;
   logic        we3;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        wb_busy;
`ifdef REGFILE_WCNT_EN
   logic [31:0] wcnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit en_cmp  = 0;

   rv_regfile_wb #(.XLEN(32), .NREG(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we3     (we3),
      .a3      (a3),
      .wd3     (wd3),
      .a1      (a1),
      .a2      (a2),
      .rd1     (rd1),
      .rd2     (rd2),
      .wb_busy (wb_busy)
`ifdef REGFILE_WCNT_EN
      ,
      .wcnt    (wcnt)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference: architectural value visible from the cycle after a write is presented,
   // busy flag = a real write was taken at the last edge, count of writes already committed.
   logic [31:0] vis [32];
   bit          m_busy;
   int unsigned m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) vis[i] <= 32'd0;
         m_busy <= 0;
         m_cnt  <= 0;
      end else begin
         if (m_busy) m_cnt <= m_cnt + 1;
         m_busy <= we3 && (a3 != 0);
         if (we3 && (a3 != 0)) vis[a3] <= wd3;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (en_cmp) begin
         chk("model_rd1", rd1, (a1 == 0) ? 32'd0 : vis[a1]);
         chk("model_rd2", rd2, (a2 == 0) ? 32'd0 : vis[a2]);
         chk("model_busy", {31'd0, wb_busy}, {31'd0, m_busy});
`ifdef REGFILE_WCNT_EN
         chk("model_wcnt", wcnt, m_cnt);
`endif
      end
   end

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] d,
                        input logic [4:0] ra1, input logic [4:0] ra2);
      @(posedge clk);
      #1;
      we3 = w; a3 = wa; wd3 = d; a1 = ra1; a2 = ra2;
   endtask

   initial begin
      rst_n = 0; we3 = 0; a3 = 0; wd3 = 0; a1 = 5; a2 = 31;
      en_cmp = 1;
      @(negedge clk);
      chk("reset_rd1", rd1, 32'd0);
      chk("reset_rd2", rd2, 32'd0);
      chk("reset_busy", {31'd0, wb_busy}, 32'd0);
      @(posedge clk); #1; rst_n = 1;

      // Write then read: old value, bypass, array
      drive(1, 3, 32'hDEADBEEF, 3, 3);
      @(negedge clk); chk("wr_same_cycle", rd1, 32'd0);
      drive(0, 0, 0, 3, 0);
      @(negedge clk); chk("wr_bypass", rd1, 32'hDEADBEEF);
      chk("wr_busy", {31'd0, wb_busy}, 32'd1);
      drive(0, 0, 0, 3, 3);
      @(negedge clk); chk("wr_array", rd1, 32'hDEADBEEF);
      chk("wr_idle_busy", {31'd0, wb_busy}, 32'd0);

      // x0 discard
      drive(1, 0, 32'h12345678, 0, 0);
      @(negedge clk); chk("x0_rd1", rd1, 32'd0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk); chk("x0_rd1_after", rd1, 32'd0);
      chk("x0_busy", {31'd0, wb_busy}, 32'd0);

      // Back-to-back to the same register
      drive(1, 7, 32'h1, 7, 7);
      drive(1, 7, 32'h2, 7, 7);
      drive(0, 0, 0, 7, 7);
      @(negedge clk); chk("b2b_bypass", rd1, 32'h2);
      drive(0, 0, 0, 7, 7);
      @(negedge clk); chk("b2b_array", rd2, 32'h2);

      // Dual-port bypass hit
      drive(1, 9, 32'hA5A5A5A5, 0, 0);
      drive(0, 0, 0, 9, 9);
      @(negedge clk); chk("dual_rd1", rd1, 32'hA5A5A5A5);
      chk("dual_rd2", rd2, 32'hA5A5A5A5);
      drive(0, 0, 0, 9, 3);
`ifdef REGFILE_WCNT_EN
      @(negedge clk); chk("wcnt_four", wcnt, 32'd4);
`endif

      // Reset while a write is staged
      drive(1, 4, 32'h55, 4, 0);
      @(posedge clk); #1;
      rst_n = 0; we3 = 0; a1 = 5; a2 = 31;
      @(negedge clk); chk("rst_mid_rd1", rd1, 32'd0);
      chk("rst_mid_rd2", rd2, 32'd0);
      chk("rst_mid_busy", {31'd0, wb_busy}, 32'd0);
`ifdef REGFILE_WCNT_EN
      chk("rst_mid_wcnt", wcnt, 32'd0);
`endif
      @(posedge clk); #1; rst_n = 1;
      drive(0, 0, 0, 4, 4);
      @(negedge clk); chk("rst_lost_x4", rd1, 32'd0);
      drive(1, 1, 32'h11, 1, 2);
      drive(1, 2, 32'h22, 1, 2);
      drive(1, 3, 32'h33, 1, 2);
      drive(0, 0, 0, 3, 4);
      drive(0, 0, 0, 3, 4);
      @(negedge clk); chk("post_rst_x3", rd1, 32'h33);
      chk("post_rst_x4", rd2, 32'd0);
`ifdef REGFILE_WCNT_EN
      chk("post_rst_wcnt", wcnt, 32'd3);
`endif

      // Random traffic, biased toward a few registers so bypass hits are common
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] wa, r1, r2;
         wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
         if ($urandom_range(0, 299) == 0) begin
            @(posedge clk); #1;
            rst_n = 0;
            @(posedge clk); #1;
            rst_n = 1;
         end
      end

      @(negedge clk);
      en_cmp = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
